// File: rtl/perceptron_pkg.sv
// Shared types and constants for the perceptron training sequencer.
package perceptron_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CLR       = 3'd1,
    PRESENT   = 3'd2,
    WAIT      = 3'd3,
    CHECK     = 3'd4,
    EPOCH_END = 3'd5,
    DONE      = 3'd6
  } state_e;

  localparam logic [1:0] RES_POS  = 2'b01;
  localparam logic [1:0] RES_NEG  = 2'b11;
  localparam int         SAMPLE_W = 8;

endpackage

// File: rtl/perceptron_train_ctrl_if.sv
// Host sample-load handshake. A sample transfers on a clock edge where load_valid && load_ready;
// the host must hold load_in/load_exp stable while load_valid is high and ready is low.
interface perceptron_train_ctrl_if;
  logic       load_valid;
  logic       load_ready;
  logic [6:0] load_in;
  logic       load_exp;

  modport master (output load_valid, output load_in, output load_exp, input load_ready);
  modport slave  (input load_valid, input load_in, input load_exp, output load_ready);
endinterface

// File: rtl/perceptron_sample_buf.sv
// Sample store: one synchronous write port, one asynchronous read port, data not reset.
module perceptron_sample_buf #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/perceptron_train_ctrl.sv
// Training sequencer: buffers labelled samples, replays them in epochs to the perceptron and scores results.
// Optional TRAIN_CYCLE_CNT_EN adds a saturating busy-cycle counter output cycle_cnt.
module perceptron_train_ctrl
  import perceptron_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int EVAL_LAT   = 3,
  parameter int MAX_EPOCHS = 16,
  parameter int CLR_CYCLES = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  perceptron_train_ctrl_if.slave          load,
  input  logic                            clear,
  input  logic                            start,
  input  logic                            abort,
  input  logic [7:0]                      thresh_cfg,
  output logic                            busy,
  output logic                            done,
  output logic                            converged,
  output logic [$clog2(MAX_EPOCHS+1)-1:0] epoch_cnt,
  output logic [$clog2(DEPTH+1)-1:0]      err_cnt,
  output logic                            p_reset_n,
  output logic [6:0]                      p_in,
  output logic [7:0]                      p_threshold,
  output logic                            p_exp_res,
  input  logic [1:0]                      p_result,
`ifdef TRAIN_CYCLE_CNT_EN
  output logic [15:0]                     cycle_cnt,
`endif
  output logic [2:0]                      state_dbg
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH+1);
  localparam int EW   = $clog2(MAX_EPOCHS+1);
  localparam int TMAX = (EVAL_LAT > CLR_CYCLES) ? EVAL_LAT : CLR_CYCLES;
  localparam int TW   = $clog2(TMAX+1);

  state_e               state;
  logic [CW-1:0]        count;
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [TW-1:0]        tmr;
  logic [SAMPLE_W-1:0]  rd_data;
  logic                 wr_en, start_ok, last, mistake;

  assign load.load_ready = (state == IDLE) && (count < CW'(DEPTH));
  assign wr_en    = load.load_valid && load.load_ready && !clear;
  // abort and clear both take priority over a start issued on the same cycle
  assign start_ok = (state == IDLE) && start && !abort && !clear && (count != '0);
  assign last     = (CW'(rd_ptr) == count - CW'(1));
  assign mistake  = !((p_exp_res && p_result == RES_POS) || (!p_exp_res && p_result == RES_NEG));
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign state_dbg = state;

  perceptron_sample_buf #(.DEPTH(DEPTH), .W(SAMPLE_W)) u_buf (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata ({load.load_exp, load.load_in}),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;      count <= '0;      wr_ptr <= '0;     rd_ptr <= '0;
      tmr <= '0;          converged <= 1'b0; epoch_cnt <= '0; err_cnt <= '0;
      p_reset_n <= 1'b0;  p_in <= '0;       p_threshold <= '0; p_exp_res <= 1'b0;
    end else if (state == IDLE) begin
      p_reset_n <= 1'b1;
      if (clear) begin
        count  <= '0;
        wr_ptr <= '0;
      end else if (wr_en) begin
        count  <= count + CW'(1);
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (start_ok) begin
        p_threshold <= thresh_cfg;
        epoch_cnt   <= '0;
        err_cnt     <= '0;
        converged   <= 1'b0;
        p_reset_n   <= 1'b0;
        tmr         <= '0;
        state       <= CLR;
      end
    end else if (abort) begin
      converged <= 1'b0;
      state     <= IDLE;
    end else begin
      case (state)
        CLR: begin
          if (tmr == TW'(CLR_CYCLES-1)) begin
            p_reset_n <= 1'b1;
            rd_ptr    <= '0;
            state     <= PRESENT;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        PRESENT: begin
          p_in      <= rd_data[6:0];
          p_exp_res <= rd_data[7];
          tmr       <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          if (tmr == TW'(EVAL_LAT-1)) state <= CHECK;
          else                        tmr   <= tmr + TW'(1);
        end
        CHECK: begin
          err_cnt <= err_cnt + CW'(mistake);
          if (last) begin
            state <= EPOCH_END;
          end else begin
            rd_ptr <= rd_ptr + AW'(1);
            state  <= PRESENT;
          end
        end
        EPOCH_END: begin
          epoch_cnt <= epoch_cnt + EW'(1);
          if (err_cnt == '0) begin
            converged <= 1'b1;
            state     <= DONE;
          end else if (epoch_cnt + EW'(1) == EW'(MAX_EPOCHS)) begin
            converged <= 1'b0;
            state     <= DONE;
          end else begin
            err_cnt <= '0;
            rd_ptr  <= '0;
            state   <= PRESENT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TRAIN_CYCLE_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                      cycle_cnt <= '0;
    else if (start_ok)                              cycle_cnt <= '0;
    else if (state != IDLE && cycle_cnt != 16'hFFFF) cycle_cnt <= cycle_cnt + 16'd1;
  end
`endif

endmodule
